// File: rtl/sad_min_select_pkg.sv
// Shared motion-estimation definitions: default widths, controller state
// encoding and the signed motion-vector type.
package me_defs;

    localparam int unsigned DEF_INPUT_PSAD_BITS_PER_PIXEL = 11;
    localparam int unsigned DEF_PIXELS_IN_BATCH           = 16;
    localparam int unsigned DEF_MV_BITS                   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic signed [DEF_MV_BITS-1:0] mv_t;

    // Bits needed to index n items; never less than one so ports stay legal.
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sad_min_select_if.sv
// Beat/result bundle between the AD chain, the ME controller and the
// minimum-SAD selector.
interface sad_min_select_if
    import me_defs::*;
#(
    parameter int unsigned PIXELS_IN_BATCH           = DEF_PIXELS_IN_BATCH,
    parameter int unsigned INPUT_PSAD_BITS_PER_PIXEL = DEF_INPUT_PSAD_BITS_PER_PIXEL,
    parameter int unsigned MV_BITS                   = DEF_MV_BITS
);

    logic                                                 start;
    logic [INPUT_PSAD_BITS_PER_PIXEL*PIXELS_IN_BATCH-1:0] psad_in;
    logic                                                 psad_valid;
    logic                                                 psad_ready;
    logic                                                 busy;
    logic                                                 done;
    logic [INPUT_PSAD_BITS_PER_PIXEL-1:0]                 best_sad;
    logic signed [MV_BITS-1:0]                            best_mv_x;
    logic signed [MV_BITS-1:0]                            best_mv_y;

    modport master (
        output start, psad_in, psad_valid,
        input  psad_ready, busy, done, best_sad, best_mv_x, best_mv_y
    );

    modport slave (
        input  start, psad_in, psad_valid,
        output psad_ready, busy, done, best_sad, best_mv_x, best_mv_y
    );

endinterface

// File: rtl/sad_lane_min.sv
// Combinational min-reduction over a vector of per-lane SADs. Returns the
// minimum value and its lane; ties resolve to the lowest lane.
module sad_lane_min
    import me_defs::*;
#(
    parameter int unsigned LANES = DEF_PIXELS_IN_BATCH,
    parameter int unsigned W     = DEF_INPUT_PSAD_BITS_PER_PIXEL,
    localparam int unsigned IDX_W = idx_bits(LANES)
) (
    input  logic [LANES*W-1:0] sad_vec_i,
    output logic [W-1:0]       min_sad_o,
    output logic [IDX_W-1:0]   min_idx_o
);

    localparam int unsigned LEVELS = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int unsigned SLOTS  = 1 << LEVELS;

    logic [W-1:0]     val [SLOTS];
    logic [IDX_W-1:0] idx [SLOTS];

    // Pairwise tree reduced in place; the right operand wins only on strict
    // less-than, so lower lanes (and real lanes over all-ones padding) win ties.
    always_comb begin
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (i < LANES) val[i] = sad_vec_i[i*W +: W];
            else           val[i] = '1;
            idx[i] = IDX_W'(i);
        end
        for (int unsigned lvl = 0; lvl < LEVELS; lvl++) begin
            for (int unsigned i = 0; i < (SLOTS >> (lvl + 1)); i++) begin
                if (val[2*i+1] < val[2*i]) begin
                    val[i] = val[2*i+1];
                    idx[i] = idx[2*i+1];
                end else begin
                    val[i] = val[2*i];
                    idx[i] = idx[2*i];
                end
            end
        end
        min_sad_o = val[0];
        min_idx_o = idx[0];
    end

endmodule

// File: rtl/sad_min_select.sv
// Minimum-SAD selector at the tail of the AD chain: consumes raster-ordered
// beats of candidate SADs, keeps the running minimum and reports it as a
// signed motion vector with a one-cycle done pulse.
module sad_min_select
    import me_defs::*;
#(
    parameter int unsigned PIXELS_IN_BATCH           = DEF_PIXELS_IN_BATCH,
    parameter int unsigned INPUT_PSAD_BITS_PER_PIXEL = DEF_INPUT_PSAD_BITS_PER_PIXEL,
    parameter int unsigned SEARCH_W                  = 16,
    parameter int unsigned SEARCH_H                  = 16,
    parameter int unsigned MV_BITS                   = DEF_MV_BITS
) (
    input  logic             clk,
    input  logic             rst,
    sad_min_select_if.slave  bus
);

    localparam int unsigned W     = INPUT_PSAD_BITS_PER_PIXEL;
    localparam int unsigned COL_W = idx_bits(SEARCH_W);
    localparam int unsigned ROW_W = idx_bits(SEARCH_H);
    localparam int unsigned IDX_W = idx_bits(PIXELS_IN_BATCH);

    localparam logic [COL_W-1:0]   COL_LAST = COL_W'(SEARCH_W - PIXELS_IN_BATCH);
    localparam logic [COL_W-1:0]   COL_STEP = COL_W'(PIXELS_IN_BATCH);
    localparam logic [ROW_W-1:0]   ROW_LAST = ROW_W'(SEARCH_H - 1);
    localparam logic [MV_BITS-1:0] MV_X_OFF = MV_BITS'(SEARCH_W / 2);
    localparam logic [MV_BITS-1:0] MV_Y_OFF = MV_BITS'(SEARCH_H / 2);

    state_t                    state_q, state_d;
    logic [COL_W-1:0]          col_base_q, col_base_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic                      first_q, first_d;
    logic                      stage_valid_q, stage_valid_d;
    logic [W-1:0]              stage_sad_q, stage_sad_d;
    logic [COL_W-1:0]          stage_col_q, stage_col_d;
    logic [ROW_W-1:0]          stage_row_q, stage_row_d;
    logic [W-1:0]              best_sad_q, best_sad_d;
    logic signed [MV_BITS-1:0] best_mv_x_q, best_mv_x_d;
    logic signed [MV_BITS-1:0] best_mv_y_q, best_mv_y_d;

    logic [W-1:0]     lane_min;
    logic [IDX_W-1:0] lane_idx;
    logic             accept;
    logic             last_beat;
    logic             take_start;
    logic             merge_upd;

    sad_lane_min #(
        .LANES (PIXELS_IN_BATCH),
        .W     (W)
    ) u_lane_min (
        .sad_vec_i (bus.psad_in),
        .min_sad_o (lane_min),
        .min_idx_o (lane_idx)
    );

    assign accept     = (state_q == ACCUM) && bus.psad_valid;
    assign last_beat  = accept && (row_q == ROW_LAST) && (col_base_q == COL_LAST);
    assign take_start = (state_q == IDLE) && bus.start;
    assign merge_upd  = stage_valid_q && (first_q || (stage_sad_q < best_sad_q));

    assign bus.psad_ready = (state_q == ACCUM);
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.best_sad   = best_sad_q;
    assign bus.best_mv_x  = best_mv_x_q;
    assign bus.best_mv_y  = best_mv_y_q;

    // Search sequencing: wait for start, take beats, drain the stage, pulse done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = ACCUM;
            ACCUM:   if (last_beat) state_d = FLUSH;
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Position counters, stage register and best-candidate merge.
    always_comb begin
        col_base_d    = col_base_q;
        row_d         = row_q;
        first_d       = first_q;
        stage_valid_d = accept;
        stage_sad_d   = stage_sad_q;
        stage_col_d   = stage_col_q;
        stage_row_d   = stage_row_q;
        best_sad_d    = best_sad_q;
        best_mv_x_d   = best_mv_x_q;
        best_mv_y_d   = best_mv_y_q;

        if (take_start) begin
            col_base_d = '0;
            row_d      = '0;
            first_d    = 1'b1;
        end

        if (accept) begin
            stage_sad_d = lane_min;
            stage_col_d = col_base_q + COL_W'(lane_idx);
            stage_row_d = row_q;
            if (col_base_q == COL_LAST) begin
                col_base_d = '0;
                row_d      = row_q + ROW_W'(1);
            end else begin
                col_base_d = col_base_q + COL_STEP;
            end
        end

        if (stage_valid_q) first_d = 1'b0;

        if (merge_upd) begin
            best_sad_d  = stage_sad_q;
            best_mv_x_d = MV_BITS'(stage_col_q) - MV_X_OFF;
            best_mv_y_d = MV_BITS'(stage_row_q) - MV_Y_OFF;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_base_q    <= '0;
            row_q         <= '0;
            first_q       <= 1'b0;
            stage_valid_q <= 1'b0;
            stage_sad_q   <= '0;
            stage_col_q   <= '0;
            stage_row_q   <= '0;
            best_sad_q    <= '1;
            best_mv_x_q   <= '0;
            best_mv_y_q   <= '0;
        end else begin
            col_base_q    <= col_base_d;
            row_q         <= row_d;
            first_q       <= first_d;
            stage_valid_q <= stage_valid_d;
            stage_sad_q   <= stage_sad_d;
            stage_col_q   <= stage_col_d;
            stage_row_q   <= stage_row_d;
            best_sad_q    <= best_sad_d;
            best_mv_x_q   <= best_mv_x_d;
            best_mv_y_q   <= best_mv_y_d;
        end
    end

endmodule

// File: tb/tb_sad_min_select.sv
// Randomized bench for sad_min_select: a default 16x16 instance and a 32x4
// instance share the beat bus; a window-level model predicts handshake,
// done timing and the earliest raster minimum.
module tb_sad_min_select;

    localparam int P   = 16;
    localparam int W   = 11;
    localparam int MVB = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           start0, start1;
    logic [P*W-1:0] psad_in;
    logic           psad_valid;
    bit             cfg;

    int checks = 0;
    int errors = 0;

    sad_min_select_if #(.PIXELS_IN_BATCH(P), .INPUT_PSAD_BITS_PER_PIXEL(W), .MV_BITS(MVB)) bus0 ();
    sad_min_select_if #(.PIXELS_IN_BATCH(P), .INPUT_PSAD_BITS_PER_PIXEL(W), .MV_BITS(MVB)) bus1 ();

    assign bus0.start      = start0;
    assign bus0.psad_in    = psad_in;
    assign bus0.psad_valid = psad_valid;
    assign bus1.start      = start1;
    assign bus1.psad_in    = psad_in;
    assign bus1.psad_valid = psad_valid;

    sad_min_select #(.PIXELS_IN_BATCH(P), .INPUT_PSAD_BITS_PER_PIXEL(W),
                     .SEARCH_W(16), .SEARCH_H(16), .MV_BITS(MVB))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));

    sad_min_select #(.PIXELS_IN_BATCH(P), .INPUT_PSAD_BITS_PER_PIXEL(W),
                     .SEARCH_W(32), .SEARCH_H(4), .MV_BITS(MVB))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    // Selected instance and the idle one.
    logic                  s_ready, s_busy, s_done, o_busy, o_done;
    logic [W-1:0]          s_sad;
    logic signed [MVB-1:0] s_mvx, s_mvy;
    assign s_ready = cfg ? bus1.psad_ready : bus0.psad_ready;
    assign s_busy  = cfg ? bus1.busy       : bus0.busy;
    assign s_done  = cfg ? bus1.done       : bus0.done;
    assign s_sad   = cfg ? bus1.best_sad   : bus0.best_sad;
    assign s_mvx   = cfg ? bus1.best_mv_x  : bus0.best_mv_x;
    assign s_mvy   = cfg ? bus1.best_mv_y  : bus0.best_mv_y;
    assign o_busy  = cfg ? bus0.busy       : bus1.busy;
    assign o_done  = cfg ? bus0.done       : bus1.done;

    int cur_sw = 16, cur_sh = 16, n_beats = 16;
    int stim [0:511];

    // Behavioural model state.
    int cyc = 0;
    bit m_active = 0;
    int m_acc = 0;
    int m_done_at = -10;
    int m_sad [2] = '{2047, 2047};
    int m_mvx [2] = '{0, 0};
    int m_mvy [2] = '{0, 0};
    int mwin [0:511];
    int done_pulses = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic set_cfg(input bit c);
        cfg     = c;
        cur_sw  = c ? 32 : 16;
        cur_sh  = c ? 4 : 16;
        n_beats = (cur_sw / P) * cur_sh;
    endtask

    function automatic logic [P*W-1:0] beat_data(input int b);
        logic [P*W-1:0] v;
        int bpr, r, cb;
        v = '0;
        if (b >= n_beats) return v;
        bpr = cur_sw / P;
        r   = b / bpr;
        cb  = (b % bpr) * P;
        for (int k = 0; k < P; k++) v[k*W +: W] = W'(stim[r*cur_sw + cb + k]);
        return v;
    endfunction

    // Model: acts on the inputs seen at each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_active  = 0;
                m_acc     = 0;
                m_done_at = -10;
                for (int c = 0; c < 2; c++) begin
                    m_sad[c] = 2047; m_mvx[c] = 0; m_mvy[c] = 0;
                end
            end else if (!m_active) begin
                if (cfg ? start1 : start0) begin
                    m_active = 1;
                    m_acc    = 0;
                end
            end else if (m_acc < n_beats) begin
                if (psad_valid) begin
                    int bpr, r, cb;
                    bpr = cur_sw / P;
                    r   = m_acc / bpr;
                    cb  = (m_acc % bpr) * P;
                    for (int k = 0; k < P; k++)
                        mwin[r*cur_sw + cb + k] = int'(psad_in[k*W +: W]);
                    m_acc++;
                    if (m_acc == n_beats) begin
                        int bs, bi;
                        m_done_at = cyc + 2;
                        bs = mwin[0];
                        bi = 0;
                        for (int i = 1; i < n_beats * P; i++)
                            if (mwin[i] < bs) begin bs = mwin[i]; bi = i; end
                        m_sad[cfg] = bs;
                        m_mvx[cfg] = (bi % cur_sw) - cur_sw / 2;
                        m_mvy[cfg] = (bi / cur_sw) - cur_sh / 2;
                    end
                end
            end else if (cyc == m_done_at) begin
                m_active = 0;
            end
            cyc++;
        end
    end

    // Compare process: every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_ready", int'(s_ready), 0);
                chk("rst_busy", int'(s_busy), 0);
                chk("rst_done", int'(s_done), 0);
                chk("rst_best_sad", int'(s_sad), 2047);
                chk("rst_mv_x", int'(s_mvx), 0);
                chk("rst_mv_y", int'(s_mvy), 0);
                chk("rst_other_busy", int'(o_busy), 0);
            end else begin
                bit exp_done;
                exp_done = m_active && (cyc == m_done_at);
                chk("psad_ready", int'(s_ready), int'(m_active && (m_acc < n_beats)));
                chk("busy", int'(s_busy), int'(m_active));
                chk("done", int'(s_done), int'(exp_done));
                chk("other_busy", int'(o_busy), 0);
                chk("other_done", int'(o_done), 0);
                if (!m_active || exp_done) begin
                    chk("best_sad", int'(s_sad), m_sad[cfg]);
                    chk("best_mv_x", int'(s_mvx), m_mvx[cfg]);
                    chk("best_mv_y", int'(s_mvy), m_mvy[cfg]);
                end
                if (s_done) done_pulses++;
            end
        end
    end

    int cap_sad, cap_mvx, cap_mvy;

    // vmode: 0 always valid, 1 toggling, 2 random stalls.
    task automatic run_search(input int vmode, input bit mid_start, input int abort_at);
        int  b = 0;
        int  t = 0;
        bit  rdy;
        bit  seen = 0;
        @(posedge clk); #1;
        if (cfg) start1 = 1'b1; else start0 = 1'b1;
        psad_valid = 1'b1;
        psad_in    = beat_data(0);
        while (b < n_beats && t < 400) begin
            @(negedge clk) rdy = s_ready;
            @(posedge clk);
            if (psad_valid && rdy) b++;
            #1;
            start0 = 1'b0;
            start1 = 1'b0;
            t++;
            if (abort_at > 0 && b == abort_at) begin
                psad_valid = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                return;
            end
            if (mid_start && t == 5) begin
                if (cfg) start1 = 1'b1; else start0 = 1'b1;
            end
            case (vmode)
                1:       psad_valid = (t % 2 == 0);
                2:       psad_valid = ($urandom_range(0, 3) != 0);
                default: psad_valid = 1'b1;
            endcase
            psad_in = beat_data(b);
        end
        psad_valid = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        chk("beats_accepted", b, n_beats);
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (s_done) begin
                seen    = 1;
                cap_sad = int'(s_sad);
                cap_mvx = int'(s_mvx);
                cap_mvy = int'(s_mvy);
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 512; i++) stim[i] = v;
    endtask

    task automatic fill_rand(input int hi);
        for (int i = 0; i < 512; i++) stim[i] = $urandom_range(0, hi);
    endtask

    initial begin
        int dp;
        rst        = 1'b1;
        start0     = 1'b0;
        start1     = 1'b0;
        psad_valid = 1'b0;
        psad_in    = '0;
        set_cfg(0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_best_sad", int'(s_sad), 2047);
        chk("reset_busy", int'(s_busy), 0);

        // Single minimum at (row 3, col 5).
        fill(500);
        stim[3*16 + 5] = 12;
        dp = done_pulses;
        run_search(0, 0, 0);
        chk("t1_done_once", done_pulses - dp, 1);
        chk("t1_sad", cap_sad, 12);
        chk("t1_mv_x", cap_mvx, -3);
        chk("t1_mv_y", cap_mvy, -5);

        // All-ones window: first-merge rule picks index 0.
        fill(2047);
        run_search(0, 0, 0);
        chk("t2_sad", cap_sad, 2047);
        chk("t2_mv_x", cap_mvx, -8);
        chk("t2_mv_y", cap_mvy, -8);

        // Tie: earliest in raster order wins.
        fill(100);
        stim[0*16 + 9]  = 7;
        stim[10*16 + 2] = 7;
        run_search(0, 0, 0);
        chk("t3_sad", cap_sad, 7);
        chk("t3_mv_x", cap_mvx, 1);
        chk("t3_mv_y", cap_mvy, -8);

        // Toggling valid with a stray start during ACCUM.
        fill_rand(2047);
        dp = done_pulses;
        run_search(1, 1, 0);
        chk("t4_done_once", done_pulses - dp, 1);

        // Abort after beat 8, then a full search.
        fill_rand(2047);
        dp = done_pulses;
        run_search(0, 0, 8);
        chk("t5_no_done", done_pulses - dp, 0);
        chk("t5_best_sad", int'(s_sad), 2047);
        chk("t5_busy", int'(s_busy), 0);
        fill_rand(2047);
        dp = done_pulses;
        run_search(2, 0, 0);
        chk("t5_recover_done", done_pulses - dp, 1);

        // Wide window on the 32x4 instance.
        set_cfg(1);
        fill(300);
        stim[2*32 + 17] = 5;
        run_search(0, 0, 0);
        chk("t6_sad", cap_sad, 5);
        chk("t6_mv_x", cap_mvx, 1);
        chk("t6_mv_y", cap_mvy, 0);

        // Randomized searches on both instances; small ranges force ties.
        for (int n = 0; n < 8; n++) begin
            set_cfg(n[0]);
            fill_rand((n % 3 == 0) ? 15 : 2047);
            run_search(n % 3, bit'($urandom_range(0, 1)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
